// File: rtl/valet_rtl_pkg.sv
`default_nettype none
// ============================================================================
// Package  : valet_rtl_pkg
// Brief    : Shared types, default widths and the lowest-free-slot encoder
//            used by the valet parking admission stage.
// Revision : 1.0
// ============================================================================
package valet_rtl_pkg;

  localparam int NUM_SLOTS_DEF = 8;
  localparam int DEPTH_DEF     = 4;
  localparam int PLATE_W_DEF   = 16;
  localparam int CYCLE_W_DEF   = 16;
  localparam int MAX_SLOTS     = 64;
  localparam int MAX_SLOT_W    = 6;

  typedef struct packed {
    logic [PLATE_W_DEF-1:0] plate;
    logic                   vip;
    logic [CYCLE_W_DEF-1:0] stamp;
  } car_entry_t;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    OFFER = 1'b1
  } park_state_e;

  // Scans downward so the lowest free index below n wins; all-full returns 0.
  function automatic logic [MAX_SLOT_W-1:0] lowest_free(
    input logic [MAX_SLOTS-1:0] occ,
    input int                   n
  );
    logic [MAX_SLOT_W-1:0] idx;
    idx = '0;
    for (int i = MAX_SLOTS - 1; i >= 0; i--) begin
      if (i < n && !occ[i]) idx = MAX_SLOT_W'(i);
    end
    return idx;
  endfunction

endpackage
`default_nettype wire

// File: rtl/valet_fifo.sv
`default_nettype none
// ============================================================================
// Module   : valet_fifo
// Brief    : Synchronous FIFO with push/pop/full/empty/count; head is read
//            combinationally from storage.
// Revision : 1.0
// ============================================================================
module valet_fifo #(
  parameter  int WIDTH = 8,
  parameter  int DEPTH = 4,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_data,
  output logic             full,
  output logic             empty,
  output logic [CNT_W-1:0] count
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             do_push, do_pop;

  assign full     = (count_q == CNT_W'(DEPTH));
  assign empty    = (count_q == '0);
  assign count    = count_q;
  assign pop_data = mem_q[rd_ptr_q];
  assign do_push  = push & ~full;
  assign do_pop   = pop & ~empty;

  always_comb begin
    mem_d = mem_q;
    if (do_push) mem_d[wr_ptr_q] = push_data;
    wr_ptr_d = wr_ptr_q + PTR_W'(do_push);
    rd_ptr_d = rd_ptr_q + PTR_W'(do_pop);
    count_d  = count_q + CNT_W'(do_push) - CNT_W'(do_pop);
  end

  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule
`default_nettype wire

// File: rtl/valet_park_alloc.sv
`default_nettype none
// ============================================================================
// Module   : valet_park_alloc
// Brief    : Arrival queue plus lowest-free-slot allocator with park and
//            retrieval handshakes. VALET_VIP_PRIORITY_EN adds a VIP-first queue.
// Revision : 1.0
// ============================================================================
module valet_park_alloc
  import valet_rtl_pkg::*;
#(
  parameter  int NUM_SLOTS = NUM_SLOTS_DEF,
  parameter  int DEPTH     = DEPTH_DEF,
  parameter  int PLATE_W   = PLATE_W_DEF,
  parameter  int CYCLE_W   = CYCLE_W_DEF,
  localparam int SLOT_W    = $clog2(NUM_SLOTS),
  localparam int QCNT_W    = $clog2(2 * DEPTH + 1),
  localparam int LOT_W     = $clog2(NUM_SLOTS + 1)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               arr_valid,
  output logic               arr_ready,
  input  logic [PLATE_W-1:0] arr_plate,
  input  logic               arr_vip,
  output logic               park_valid,
  input  logic               park_ready,
  output logic [PLATE_W-1:0] park_plate,
  output logic               park_vip,
  output logic [SLOT_W-1:0]  park_slot,
  output logic [CYCLE_W-1:0] park_wait,
  input  logic               ret_valid,
  input  logic [SLOT_W-1:0]  ret_slot,
  output logic               ret_err,
  output logic [QCNT_W-1:0]  q_count,
  output logic [LOT_W-1:0]   lot_count,
  output logic               lot_full
);

  localparam int FCNT_W = $clog2(DEPTH + 1);

  typedef struct packed {
    logic [PLATE_W-1:0] plate;
    logic               vip;
    logic [CYCLE_W-1:0] stamp;
  } entry_t;

  park_state_e          state_q, state_d;
  logic                 park_valid_q, park_valid_d;
  logic [PLATE_W-1:0]   plate_q, plate_d;
  logic                 vip_q, vip_d;
  logic [SLOT_W-1:0]    slot_q, slot_d;
  logic [CYCLE_W-1:0]   wait_q, wait_d;
  logic [NUM_SLOTS-1:0] occ_q, occ_d;
  logic [LOT_W-1:0]     lot_cnt_q, lot_cnt_d;
  logic [CYCLE_W-1:0]   cyc_q, cyc_d;
  logic                 alive_q, alive_d;
  logic                 ret_err_q, ret_err_d;

  entry_t               push_entry, head_entry;
  logic                 arr_fire, alloc, queue_full, queue_empty;
  logic [SLOT_W-1:0]    free_slot;
  logic                 any_free, ret_in_range, ret_ok;

  assign push_entry = {arr_plate, arr_vip, cyc_q};
  assign arr_ready  = alive_q & ~queue_full;
  assign arr_fire   = arr_valid & arr_ready;

`ifdef VALET_VIP_PRIORITY_EN
  entry_t            vip_head, nrm_head;
  logic              vip_full, vip_empty, nrm_full, nrm_empty;
  logic [FCNT_W-1:0] vip_cnt, nrm_cnt;

  valet_fifo #(.WIDTH($bits(entry_t)), .DEPTH(DEPTH)) u_vip_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (arr_fire & arr_vip),
    .push_data (push_entry),
    .pop       (alloc & ~vip_empty),
    .pop_data  (vip_head),
    .full      (vip_full),
    .empty     (vip_empty),
    .count     (vip_cnt)
  );

  valet_fifo #(.WIDTH($bits(entry_t)), .DEPTH(DEPTH)) u_nrm_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (arr_fire & ~arr_vip),
    .push_data (push_entry),
    .pop       (alloc & vip_empty),
    .pop_data  (nrm_head),
    .full      (nrm_full),
    .empty     (nrm_empty),
    .count     (nrm_cnt)
  );

  // Ready must not depend on arr_vip, so either class being full stalls arrivals.
  assign queue_full  = vip_full | nrm_full;
  assign queue_empty = vip_empty & nrm_empty;
  assign head_entry  = vip_empty ? nrm_head : vip_head;
  assign q_count     = QCNT_W'(vip_cnt) + QCNT_W'(nrm_cnt);
`else
  logic [FCNT_W-1:0] fifo_cnt;

  valet_fifo #(.WIDTH($bits(entry_t)), .DEPTH(DEPTH)) u_arr_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (arr_fire),
    .push_data (push_entry),
    .pop       (alloc),
    .pop_data  (head_entry),
    .full      (queue_full),
    .empty     (queue_empty),
    .count     (fifo_cnt)
  );

  assign q_count = QCNT_W'(fifo_cnt);
`endif

  assign any_free     = ~&occ_q;
  assign free_slot    = SLOT_W'(lowest_free(MAX_SLOTS'(occ_q), NUM_SLOTS));
  assign ret_in_range = ({1'b0, ret_slot} < (SLOT_W + 1)'(NUM_SLOTS));
  // The slot under offer is still owned by the car being handed over.
  assign ret_ok       = ret_valid & ret_in_range & occ_q[ret_slot] &
                        ~((state_q == OFFER) & (ret_slot == slot_q));

  always_comb begin
    state_d      = state_q;
    park_valid_d = park_valid_q;
    plate_d      = plate_q;
    vip_d        = vip_q;
    slot_d       = slot_q;
    wait_d       = wait_q;
    occ_d        = occ_q;
    alloc        = 1'b0;
    case (state_q)
      IDLE: begin
        if (!queue_empty && any_free) begin
          alloc            = 1'b1;
          occ_d[free_slot] = 1'b1;
          plate_d          = head_entry.plate;
          vip_d            = head_entry.vip;
          slot_d           = free_slot;
          wait_d           = cyc_q - head_entry.stamp;
          park_valid_d     = 1'b1;
          state_d          = OFFER;
        end
      end
      OFFER: begin
        if (park_ready) begin
          park_valid_d = 1'b0;
          state_d      = IDLE;
        end
      end
      default: begin
        park_valid_d = 1'b0;
        state_d      = IDLE;
      end
    endcase
    if (ret_ok) occ_d[ret_slot] = 1'b0;
    ret_err_d = ret_valid & ~ret_ok;
    lot_cnt_d = lot_cnt_q + LOT_W'(alloc) - LOT_W'(ret_ok);
    cyc_d     = cyc_q + CYCLE_W'(1);
    alive_d   = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      park_valid_q <= 1'b0;
      plate_q      <= '0;
      vip_q        <= 1'b0;
      slot_q       <= '0;
      wait_q       <= '0;
      occ_q        <= '0;
      lot_cnt_q    <= '0;
      cyc_q        <= '0;
      alive_q      <= 1'b0;
      ret_err_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      park_valid_q <= park_valid_d;
      plate_q      <= plate_d;
      vip_q        <= vip_d;
      slot_q       <= slot_d;
      wait_q       <= wait_d;
      occ_q        <= occ_d;
      lot_cnt_q    <= lot_cnt_d;
      cyc_q        <= cyc_d;
      alive_q      <= alive_d;
      ret_err_q    <= ret_err_d;
    end
  end

  assign park_valid = park_valid_q;
  assign park_plate = plate_q;
  assign park_vip   = vip_q;
  assign park_slot  = slot_q;
  assign park_wait  = wait_q;
  assign ret_err    = ret_err_q;
  assign lot_count  = lot_cnt_q;
  assign lot_full   = (lot_cnt_q == LOT_W'(NUM_SLOTS));

endmodule
`default_nettype wire
